// File: rtl/life_sequencer.sv
// Generation sequencer for the 8x8 Game of Life engine: owns the grid register,
// paces evolution, counts generations and halts on extinction / still life.
// Optional period-2 oscillator detection is enabled by defining LIFE_OSC2_DETECT_EN.
module life_sequencer #(
    parameter int DIV_W = 24,
    parameter int GEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [63:0]       seed,
    input  logic              run,
    input  logic              step,
    input  logic [DIV_W-1:0]  rate,
    output logic [63:0]       dp_grid,
    input  logic [63:0]       dp_next,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic              update
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_EXTINCT = 2'b01;
    localparam logic [1:0] CAUSE_STILL   = 2'b10;
    localparam logic [1:0] CAUSE_OSC2    = 2'b11;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   prescaler, prescaler_nx;
    logic [63:0]        grid_nx;
    logic [GEN_W-1:0]   gen_nx;
    logic [1:0]         cause_nx;
    logic [1:0]         hit_cause;
    logic               update_nx;
    logic               evolve;
    logic               osc_hit;
    logic               gen_sat;

`ifdef LIFE_OSC2_DETECT_EN
    logic [63:0]        prev;
    logic               prev_valid;

    assign osc_hit = prev_valid && (dp_next == prev);

    // prev holds the grid from before the most recent evolve
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (load) begin
            prev_valid <= 1'b0;
        end else if (evolve) begin
            prev       <= dp_grid;
            prev_valid <= 1'b1;
        end
    end
`else
    assign osc_hit = 1'b0;
`endif

    assign gen_sat = &gen_count;

    // Halt check on pre-edge values, highest priority first
    always_comb begin
        hit_cause = CAUSE_NONE;
        if (dp_next == 64'd0)
            hit_cause = CAUSE_EXTINCT;
        else if (dp_next == dp_grid)
            hit_cause = CAUSE_STILL;
        else if (osc_hit)
            hit_cause = CAUSE_OSC2;
    end

    always_comb begin
        state_nx     = state;
        prescaler_nx = prescaler;
        grid_nx      = dp_grid;
        gen_nx       = gen_count;
        cause_nx     = halt_cause;
        update_nx    = 1'b0;
        evolve       = 1'b0;

        if (load) begin
            state_nx     = IDLE;
            grid_nx      = seed;
            gen_nx       = '0;
            prescaler_nx = '0;
            cause_nx     = CAUSE_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state_nx     = RUN;
                        prescaler_nx = '0;
                    end else if (step) begin
                        evolve = 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_nx     = IDLE;
                        prescaler_nx = '0;
                    end else if (prescaler == rate) begin
                        evolve       = 1'b1;
                        prescaler_nx = '0;
                    end else begin
                        // wraps through all-ones if rate was lowered below prescaler
                        prescaler_nx = prescaler + 1'b1;
                    end
                end
                HALT: ;
                default: state_nx = IDLE;
            endcase
        end

        if (evolve) begin
            grid_nx   = dp_next;
            update_nx = 1'b1;
            if (!gen_sat)
                gen_nx = gen_count + 1'b1;
            if (hit_cause != CAUSE_NONE) begin
                state_nx = HALT;
                cause_nx = hit_cause;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            prescaler  <= '0;
            dp_grid    <= '0;
            gen_count  <= '0;
            halt_cause <= CAUSE_NONE;
            update     <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nx;
            prescaler  <= prescaler_nx;
            dp_grid    <= grid_nx;
            gen_count  <= gen_nx;
            halt_cause <= cause_nx;
            update     <= update_nx;
            busy       <= (state_nx == RUN);
            halted     <= (state_nx == HALT);
        end
    end

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: directed scenarios plus random control traffic,
// checked each cycle against a cycle-counting behavioural model.
module tb_life_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [63:0] seed = '0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [23:0] rate = '0;

    logic [63:0] dp_grid, dp_next, dp_grid4, dp_next4;
    logic [15:0] gen_count;
    logic [3:0]  gen_count4;
    logic        busy, halted, update, busy4, halted4, update4;
    logic [1:0]  halt_cause, halt_cause4;

    int total = 0;
    int bad = 0;

    localparam logic [63:0] SINGLE  = 64'd1 << 27;
    localparam logic [63:0] BLOCK   = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);
    localparam logic [63:0] BLINKER = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    localparam logic [63:0] GLIDER  = (64'd1 << 10) | (64'd1 << 19) | (64'd1 << 25) |
                                      (64'd1 << 26) | (64'd1 << 27);

    always #5 clk = ~clk;

    // Conway rules on a bounded 8x8 board (cells outside are dead)
    function automatic logic [63:0] life(input logic [63:0] g);
        logic [63:0] o;
        int n;
        o = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8)
                            n += int'(g[(r + dr) * 8 + c + dc]);
                o[r * 8 + c] = (n == 3) || (g[r * 8 + c] && n == 2);
            end
        end
        return o;
    endfunction

    assign dp_next  = life(dp_grid);
    assign dp_next4 = life(dp_grid4);

    life_sequencer #(.DIV_W(24), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .rate(rate), .dp_grid(dp_grid), .dp_next(dp_next), .gen_count(gen_count),
        .busy(busy), .halted(halted), .halt_cause(halt_cause), .update(update)
    );

    life_sequencer #(.DIV_W(24), .GEN_W(4)) dut4 (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .rate(rate), .dp_grid(dp_grid4), .dp_next(dp_next4), .gen_count(gen_count4),
        .busy(busy4), .halted(halted4), .halt_cause(halt_cause4), .update(update4)
    );

    // Model: mode 0 idle, 1 running, 2 halted; ticks = cycles spent running since entry/last evolve
    int          m_mode, m_gen, m_ticks;
    logic [63:0] m_grid, m_prev;
    logic [1:0]  m_cause;
    logic        m_pvalid, m_upd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_gen = 0; m_ticks = 0;
        m_grid = '0; m_prev = '0; m_cause = 2'b00; m_pvalid = 1'b0; m_upd = 1'b0;
    endtask

    task automatic model_evolve();
        logic [63:0] nx;
        logic        osc_en;
`ifdef LIFE_OSC2_DETECT_EN
        osc_en = 1'b1;
`else
        osc_en = 1'b0;
`endif
        nx = life(m_grid);
        m_upd = 1'b1;
        if (nx == 64'd0) m_cause = 2'b01;
        else if (nx == m_grid) m_cause = 2'b10;
        else if (osc_en && m_pvalid && nx == m_prev) m_cause = 2'b11;
        if (m_cause != 2'b00) m_mode = 2;
        m_prev = m_grid; m_pvalid = 1'b1;
        m_grid = nx;
        m_gen++;
    endtask

    task automatic model_step(input logic ld, input logic [63:0] sd, input logic rn,
                              input logic st, input logic [23:0] rt);
        m_upd = 1'b0;
        if (ld) begin
            m_grid = sd; m_gen = 0; m_ticks = 0; m_pvalid = 1'b0; m_cause = 2'b00; m_mode = 0;
        end else if (m_mode == 0) begin
            if (rn) begin m_mode = 1; m_ticks = 0; end
            else if (st) model_evolve();
        end else if (m_mode == 1) begin
            if (!rn) m_mode = 0;
            else begin
                m_ticks++;
                if (m_ticks == int'(rt) + 1) begin
                    m_ticks = 0;
                    model_evolve();
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("dp_grid", dp_grid, m_grid);
        chk("gen_count", 64'(gen_count), 64'((m_gen > 65535) ? 65535 : m_gen));
        chk("gen_count_w4", 64'(gen_count4), 64'((m_gen > 15) ? 15 : m_gen));
        chk("busy", 64'(busy), 64'(m_mode == 1));
        chk("halted", 64'(halted), 64'(m_mode == 2));
        chk("halt_cause", 64'(halt_cause), 64'(m_cause));
        chk("update", 64'(update), 64'(m_upd));
        chk("dp_grid_w4", dp_grid4, m_grid);
    endtask

    task automatic drive(input logic ld, input logic [63:0] sd, input logic rn,
                         input logic st, input logic [23:0] rt);
        load = ld; seed = sd; run = rn; step = st; rate = rt;
        @(posedge clk);
        #1;
        model_step(ld, sd, rn, st, rt);
        compare_all();
    endtask

    initial begin
        logic        r_run;
        logic [23:0] r_rate;
        logic [63:0] r_seed;
        model_reset();
        #12;
        compare_all();
        reset = 1'b0;

        // single cell dies on the first step
        drive(1, SINGLE, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 0);

        // block is a still life
        drive(1, BLOCK, 0, 0, 0);
        repeat (4) drive(0, 0, 1, 0, 0);

        // blinker at rate 3
        drive(1, BLINKER, 0, 0, 0);
        repeat (90) drive(0, 0, 1, 0, 3);

        // glider, reload mid-run at generation 5
        drive(1, GLIDER, 0, 0, 0);
        repeat (6) drive(0, 0, 1, 0, 0);
        drive(1, BLINKER, 1, 1, 0);
        drive(0, 0, 0, 0, 0);

        // rate 9, run dropped when the prescaler reaches 9
        drive(1, GLIDER, 0, 0, 9);
        repeat (10) drive(0, 0, 1, 0, 9);
        drive(0, 0, 0, 0, 9);
        drive(0, 0, 0, 0, 9);

        // generation counter saturation on the narrow instance
        drive(1, BLINKER, 0, 0, 0);
        repeat (21) drive(0, 0, 1, 0, 0);

        // asynchronous reset in the middle of a run
        drive(1, GLIDER, 0, 0, 0);
        repeat (4) drive(0, 0, 1, 0, 0);
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all();
        @(negedge clk) reset = 1'b0;

        // randomized control traffic; rate only changes while run is low
        r_run = 1'b0;
        r_rate = 24'd1;
        repeat (900) begin
            if ($urandom_range(0, 9) == 0) r_run = ~r_run;
            if (!r_run && $urandom_range(0, 3) == 0) r_rate = 24'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: r_seed = {$urandom, $urandom};
                1: r_seed = BLINKER;
                2: r_seed = BLOCK;
                3: r_seed = GLIDER;
                4: r_seed = '0;
                default: r_seed = SINGLE | BLINKER << 24;
            endcase
            drive(($urandom_range(0, 24) == 0), r_seed, r_run, ($urandom_range(0, 3) == 0), r_rate);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
